// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: 4-bit physical-layer transmitter for the 2x16 character LCD.
// After reset it runs the controller's power-on nibble initialisation (0x3,0x3,0x3,0x2).
// It then sends {RS, RW, D[7:0]} words as two E-strobed nibbles and pulses done.
// Optional build macro LCD_OVERRUN_FLAG_EN adds a sticky 'overrun' output.
// That output flags requests dropped while busy or in the done cycle.
module lcd_bus_driver #(
  parameter int T_PWR_WAIT = 750000,
  parameter int T_SETUP    = 2,
  parameter int T_E_HIGH   = 12,
  parameter int T_HOLD     = 1,
  parameter int T_NIB_GAP  = 50,
  parameter int T_CMD_GAP  = 2000,
  parameter int T_INIT_1   = 205000,
  parameter int T_INIT_2   = 5000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_instruction,
  input  logic [9:0] db,
  output logic       done,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_data
`ifdef LCD_OVERRUN_FLAG_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [3:0] {
    PWR_WAIT, I_SETUP, I_PULSE, I_HOLD, I_GAP,
    IDLE, CAPTURE,
    HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP,
    LO_SETUP, LO_PULSE, LO_HOLD, CMD_GAP, DONE_ST
  } state_t;

  // Terminal timer values: a state exits when timer reaches length-1.
  localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(T_PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EHI   = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_NIB   = CNT_W'(T_NIB_GAP - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD_GAP - 1);
  localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(T_INIT_1 - 1);
  localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(T_INIT_2 - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] timer, cur_last;
  logic             timer_end;
  logic [1:0]       step, step_eff;
  logic             word_rs;
  logic [7:0]       word_d;
  logic [3:0]       init_nib, hi_nib, lo_nib;
  logic             hi_rs;
  logic             nxt_e, nxt_rs;
  logic [3:0]       nxt_data;

  // Read-back is unsupported, so the RW bit of the word is never used.
  logic unused_rw;
  assign unused_rw = db[8];

  // Length of the current state, in terminal-count form.
  always_comb begin
    cur_last = '0;
    case (state)
      PWR_WAIT:                   cur_last = L_PWR;
      I_SETUP, HI_SETUP, LO_SETUP: cur_last = L_SETUP;
      I_PULSE, HI_PULSE, LO_PULSE: cur_last = L_EHI;
      I_HOLD, HI_HOLD, LO_HOLD:    cur_last = L_HOLD;
      I_GAP: begin
        case (step)
          2'd0:    cur_last = L_INIT1;
          2'd1:    cur_last = L_INIT2;
          default: cur_last = L_CMD;
        endcase
      end
      NIB_GAP: cur_last = L_NIB;
      CMD_GAP: cur_last = L_CMD;
      default: cur_last = '0;
    endcase
  end

  assign timer_end = (timer == cur_last);

  // Next-state decode; IDLE is the only state that accepts a request.
  always_comb begin
    nxt = state;
    case (state)
      PWR_WAIT: if (timer_end) nxt = I_SETUP;
      I_SETUP:  if (timer_end) nxt = I_PULSE;
      I_PULSE:  if (timer_end) nxt = I_HOLD;
      I_HOLD:   if (timer_end) nxt = I_GAP;
      I_GAP:    if (timer_end) nxt = (step == 2'd3) ? IDLE : I_SETUP;
      IDLE:     if (next_instruction) nxt = CAPTURE;
      CAPTURE:  nxt = HI_SETUP;
      HI_SETUP: if (timer_end) nxt = HI_PULSE;
      HI_PULSE: if (timer_end) nxt = HI_HOLD;
      HI_HOLD:  if (timer_end) nxt = NIB_GAP;
      NIB_GAP:  if (timer_end) nxt = LO_SETUP;
      LO_SETUP: if (timer_end) nxt = LO_PULSE;
      LO_PULSE: if (timer_end) nxt = LO_HOLD;
      LO_HOLD:  if (timer_end) nxt = CMD_GAP;
      CMD_GAP:  if (timer_end) nxt = DONE_ST;
      DONE_ST:  nxt = IDLE;
      default:  nxt = PWR_WAIT;
    endcase
  end

  // Pin values for the state being entered, so the pins change with the state.
  // Entering I_SETUP from I_GAP uses the incremented step.
  // Entering HI_SETUP from CAPTURE takes the nibble straight from db.
  // The word register only loads on that same edge.
  assign step_eff = (state == I_GAP) ? step + 2'd1 : step;
  assign init_nib = (step_eff == 2'd3) ? 4'h2 : 4'h3;
  assign hi_nib   = (state == CAPTURE) ? db[7:4] : word_d[7:4];
  assign hi_rs    = (state == CAPTURE) ? db[9]   : word_rs;
  assign lo_nib   = word_d[3:0];

  // Pin drive per phase: zero everywhere outside setup/pulse/hold.
  always_comb begin
    nxt_e    = 1'b0;
    nxt_rs   = 1'b0;
    nxt_data = 4'h0;
    case (nxt)
      I_SETUP, I_HOLD:   nxt_data = init_nib;
      I_PULSE:           begin nxt_data = init_nib; nxt_e = 1'b1; end
      HI_SETUP, HI_HOLD: begin nxt_data = hi_nib; nxt_rs = hi_rs; end
      HI_PULSE:          begin nxt_data = hi_nib; nxt_rs = hi_rs; nxt_e = 1'b1; end
      LO_SETUP, LO_HOLD: begin nxt_data = lo_nib; nxt_rs = word_rs; end
      LO_PULSE:          begin nxt_data = lo_nib; nxt_rs = word_rs; nxt_e = 1'b1; end
      default: ;
    endcase
  end

  // State, timer, init step, word latch and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PWR_WAIT;
      timer     <= '0;
      step      <= '0;
      word_rs   <= 1'b0;
      word_d    <= '0;
      done      <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      state <= nxt;
      // Reload on every state entry; IDLE parks the timer at zero.
      if (nxt != state || state == IDLE) timer <= '0;
      else                               timer <= timer + 1'b1;
      if (state == I_GAP && timer_end) begin
        step <= step + 2'd1;
        if (step == 2'd3) init_done <= 1'b1;
      end
      // db becomes valid one cycle after the request, which is this cycle.
      if (state == CAPTURE) begin
        word_rs <= db[9];
        word_d  <= db[7:0];
      end
      done     <= (nxt == DONE_ST);
      busy     <= (nxt != IDLE);
      lcd_e    <= nxt_e;
      lcd_rs   <= nxt_rs;
      lcd_rw   <= 1'b0;
      lcd_data <= nxt_data;
    end
  end

`ifdef LCD_OVERRUN_FLAG_EN
  // Sticky flag for any request that arrives outside IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 overrun <= 1'b0;
    else if (next_instruction && state != IDLE) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver with shortened timing parameters.
// Expected E pulses and done times are computed from the phase lengths and queued.
// Independent monitors pop and compare them as the pins move.
module tb_lcd_bus_driver;
  localparam int T_PWR = 500, T_S = 2, T_E = 12, T_H = 1, T_NIB = 50;
  localparam int T_CMD = 300, T_I1 = 400, T_I2 = 150;
  localparam int XFER  = 1 + 2 * (T_S + T_E + T_H) + T_NIB + T_CMD;
  localparam int INIT_MAX = T_PWR + 4 * (T_S + T_E + T_H) + T_I1 + T_I2 + 2 * T_CMD + 100;

  logic clk = 1'b0, reset = 1'b1, next_instruction = 1'b0;
  logic [9:0] db = '0;
  logic done, busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;
`ifdef LCD_OVERRUN_FLAG_EN
  logic overrun;
`endif

  lcd_bus_driver #(
    .T_PWR_WAIT(T_PWR), .T_SETUP(T_S), .T_E_HIGH(T_E), .T_HOLD(T_H),
    .T_NIB_GAP(T_NIB), .T_CMD_GAP(T_CMD), .T_INIT_1(T_I1), .T_INIT_2(T_I2), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .next_instruction(next_instruction), .db(db),
    .done(done), .busy(busy), .init_done(init_done), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
`ifdef LCD_OVERRUN_FLAG_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_chk = 0, n_pass = 0, n_done = 0;
  bit rw_bad = 0, busy_bad = 0;

  typedef struct packed {
    logic [3:0] nib;
    logic       rs;
    int         rise;
    int         width;
  } pulse_t;

  pulse_t pq[$];
  int     dq[$];

  task automatic chk(input string name, input bit ok, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic int gap_len(input int s);
    return (s == 0) ? T_I1 : (s == 1) ? T_I2 : T_CMD;
  endfunction

  // Init model: 4 pulses; first rise T_PWR+T_S after release; init_done after final gap.
  task automatic push_init(input int rel, output int exp_done);
    pulse_t p;
    int t;
    t = rel + T_PWR + T_S;
    exp_done = 0;
    for (int s = 0; s < 4; s++) begin
      p.nib = (s < 3) ? 4'h3 : 4'h2; p.rs = 1'b0; p.rise = t; p.width = T_E;
      pq.push_back(p);
      exp_done = t + T_E + T_H + gap_len(s);
      t = exp_done + T_S;
    end
  endtask

  // Word model: request sampled at edge k; hi E rises after capture + setup.
  task automatic push_word(input logic [9:0] w, input int k);
    pulse_t p;
    int r1, r2;
    r1 = k + 1 + T_S;
    r2 = r1 + T_E + T_H + T_NIB + T_S;
    p.nib = w[7:4]; p.rs = w[9]; p.rise = r1; p.width = T_E; pq.push_back(p);
    p.nib = w[3:0]; p.rs = w[9]; p.rise = r2; p.width = T_E; pq.push_back(p);
    dq.push_back(r2 + T_E + T_H + T_CMD);
  endtask

  // Called at a negedge: request this cycle, valid word next cycle, junk after.
  task automatic issue(input logic [9:0] w);
    int k;
    k = cyc + 1;
    next_instruction = 1'b1;
    db = 10'($urandom_range(0, 1023));
    push_word(w, k);
    @(negedge clk);
    next_instruction = 1'b0;
    db = w;
    @(negedge clk);
    db = 10'($urandom_range(0, 1023));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2 * XFER) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 1'b0, $sformatf("busy=%b still after %0d cycles", busy, n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2 * XFER) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 1'b0, $sformatf("done=%b after %0d cycles", done, n));
  endtask

  task automatic wait_e(input logic v);
    int n = 0;
    while (lcd_e !== v && n < 2 * XFER) begin @(negedge clk); n++; end
    if (lcd_e !== v) chk("lcd_e_timeout", 1'b0, $sformatf("lcd_e=%b want %b", lcd_e, v));
  endtask

  task automatic wait_init(input int exp);
    int n = 0;
    while (!init_done && n < INIT_MAX) begin @(negedge clk); n++; end
    chk("init_done_time", init_done && cyc == exp,
        $sformatf("init_done=%b at cycle %0d, want 1 at %0d", init_done, cyc, exp));
    chk("busy_during_init", !busy_bad, $sformatf("busy dropped during init=%b want 0", busy_bad));
    busy_bad = 0;
  endtask

  // Pulse monitor: captures each E pulse, then checks the hold cycle(s) and first gap cycle.
  initial begin : mon_pulse
    bit in_p = 0, stable = 0, hold_ok = 0, gap_ok = 0;
    int post = 0;
    pulse_t got, ex;
    got = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_p = 0; post = 0;
      end else if (lcd_e) begin
        if (!in_p) begin
          in_p = 1; got.nib = lcd_data; got.rs = lcd_rs; got.rise = cyc; got.width = 0;
          stable = 1; hold_ok = 1;
        end
        got.width = got.width + 1;
        if (lcd_data != got.nib || lcd_rs != got.rs) stable = 0;
      end else if (in_p || post > 0) begin
        if (in_p) begin in_p = 0; post = 1; end
        else post++;
        if (post <= T_H) begin
          if (lcd_data != got.nib || lcd_rs != got.rs) hold_ok = 0;
        end else begin
          post = 0;
          gap_ok = (lcd_data == 4'h0 && lcd_rs == 1'b0);
          if (pq.size() == 0)
            chk("pulse_unexpected", 1'b0, $sformatf("got nib=%h rs=%b rise=%0d, want no pulse",
                got.nib, got.rs, got.rise));
          else begin
            ex = pq.pop_front();
            chk("e_pulse", got == ex && stable && hold_ok && gap_ok,
                $sformatf("got nib=%h rs=%b rise=%0d width=%0d stable=%b hold=%b gapzero=%b want nib=%h rs=%b rise=%0d width=%0d stable=1 hold=1 gapzero=1",
                got.nib, got.rs, got.rise, got.width, stable, hold_ok, gap_ok,
                ex.nib, ex.rs, ex.rise, ex.width));
          end
        end
      end
    end
  end

  // Done monitor: time of each pulse and that it lasts exactly one cycle.
  initial begin : mon_done
    bit prev = 0;
    int want;
    forever begin
      @(negedge clk);
      if (reset) prev = 0;
      else begin
        if (prev) chk("done_width", !done, $sformatf("done=%b in cycle after pulse, want 0", done));
        prev = done;
        if (done) begin
          n_done++;
          if (dq.size() == 0)
            chk("done_unexpected", 1'b0, $sformatf("done at cycle %0d, want none", cyc));
          else begin
            want = dq.pop_front();
            chk("done_time", cyc == want, $sformatf("done at cycle %0d want %0d", cyc, want));
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (lcd_rw) rw_bad = 1;
    if (!reset && !init_done && !busy) busy_bad = 1;
  end

  initial begin : stim
    int rel, exp_id, d0;
    logic [9:0] w;
    logic [9:0] rst_exp;
    rst_exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {done, init_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_data} == rst_exp,
        $sformatf("got %b want %b", {done, init_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_data}, rst_exp));
`ifdef LCD_OVERRUN_FLAG_EN
    chk("reset_overrun", overrun == 1'b0, $sformatf("got %b want 0", overrun));
`endif

    // Power-on init.
    reset = 1'b0;
    rel = cyc;
    push_init(rel, exp_id);
    wait_init(exp_id);

    // Directed words: FUNCTION_SET and a data write of 'C'.
    wait_idle(); issue(10'h028); wait_done();
    wait_idle(); issue(10'h243); wait_done();

    // Back-to-back: each request lands in the first IDLE cycle after done.
    d0 = n_done;
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      w = 10'($urandom_range(0, 1023));
      issue(w);
      wait_done();
      @(negedge clk);
    end
    chk("b2b_count", n_done - d0 == 16, $sformatf("got %0d dones want 16", n_done - d0));
`ifdef LCD_OVERRUN_FLAG_EN
    chk("overrun_clear_b2b", overrun == 1'b0, $sformatf("got %b want 0", overrun));
`endif

    // Request during the DONE cycle is dropped.
    wait_idle();
    d0 = n_done;
    w = 10'($urandom_range(0, 1023));
    issue(w);
    wait_done();
    next_instruction = 1'b1; db = 10'($urandom_range(0, 1023));
    @(negedge clk);
    next_instruction = 1'b0;
    repeat (XFER + 20) @(negedge clk);
    chk("done_cycle_req_ignored", n_done - d0 == 1, $sformatf("got %0d dones want 1", n_done - d0));
`ifdef LCD_OVERRUN_FLAG_EN
    chk("overrun_set_done", overrun == 1'b1, $sformatf("got %b want 1", overrun));
`endif

    // Request during HI_PULSE is dropped; the latched word is untouched.
    wait_idle();
    d0 = n_done;
    w = 10'($urandom_range(0, 1023));
    issue(w);
    wait_e(1'b1);
    next_instruction = 1'b1; db = ~w;
    @(negedge clk);
    next_instruction = 1'b0; db = 10'($urandom_range(0, 1023));
    @(negedge clk);
    db = 10'($urandom_range(0, 1023));
    wait_done();
    repeat (XFER + 20) @(negedge clk);
    chk("overlap_single_done", n_done - d0 == 1, $sformatf("got %0d dones want 1", n_done - d0));

    // Asynchronous reset during LO_PULSE, then a full re-init.
    wait_idle();
    w = 10'($urandom_range(0, 1023));
    issue(w);
    wait_e(1'b1); wait_e(1'b0); wait_e(1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", lcd_e == 1'b0 && done == 1'b0 && init_done == 1'b0 && busy == 1'b1,
           $sformatf("got e=%b done=%b init_done=%b busy=%b want 0 0 0 1", lcd_e, done, init_done, busy));
`ifdef LCD_OVERRUN_FLAG_EN
    chk("reset_overrun_mid", overrun == 1'b0, $sformatf("got %b want 0", overrun));
`endif
    pq.delete(); dq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    push_init(rel, exp_id);
    // Request while in PWR_WAIT must be dropped.
    @(negedge clk);
    next_instruction = 1'b1; db = 10'($urandom_range(0, 1023));
    @(negedge clk);
    next_instruction = 1'b0;
    wait_init(exp_id);
`ifdef LCD_OVERRUN_FLAG_EN
    chk("overrun_set_init", overrun == 1'b1, $sformatf("got %b want 1", overrun));
`endif

    // One more word after re-init.
    wait_idle();
    w = 10'($urandom_range(0, 1023));
    issue(w);
    wait_done();
    repeat (20) @(negedge clk);
    chk("queues_drained", pq.size() == 0 && dq.size() == 0,
        $sformatf("got %0d pulses %0d dones pending want 0 0", pq.size(), dq.size()));
    chk("lcd_rw_low", !rw_bad, $sformatf("lcd_rw seen high=%b want 0", rw_bad));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_chk, n_pass);
    $fatal(1, "watchdog");
  end
endmodule
